// File: rtl/ps2_key_mapper.sv
// rtl/ps2_key_mapper.sv - PS/2 keyboard deframer and game-action mapper
//
// Purpose:
//   Synchronizes the raw PS/2 clock/data lines and deframes 11-bit frames
//   (start, 8 data LSB first, odd parity, stop). It tracks the E0/F0
//   prefixes and maps make codes to a 3-bit game action. The action is
//   presented with a ready/read_fin handshake.
//
// Ports:
//   clk_100M   in   system clock (only clock)
//   reset_n    in   asynchronous active-low reset
//   ps2_clock  in   raw PS/2 clock (asynchronous)
//   ps2_data   in   raw PS/2 data (asynchronous)
//   read_fin   in   consumer has taken data
//   ready      out  new action valid on data
//   data       out  action code (0 up .. 6 end turn)
//   frame_err  out  one-cycle pulse on start/parity/stop error or timeout
//   dropped    out  one-cycle pulse when a mapped key is discarded
module ps2_key_mapper #(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_100M,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       read_fin,
  output logic       ready,
  output logic [2:0] data,
  output logic       frame_err,
  output logic       dropped
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Synchronizer chains: bit 0 is the first stage, MSB the last.
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall_q, fall_d;

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   stop_q, stop_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic                   ready_q, ready_d;
  logic [2:0]             data_q, data_d;
  logic                   dropped_q, dropped_d;

  logic                   din;
  logic                   frame_ok;
  logic                   map_hit;
  logic [2:0]             map_act;
  logic                   act_valid;

  assign din      = dat_sync_q[SYNC_STAGES-1];
  assign frame_ok = (^{shreg_q, par_q}) & stop_q;

  // Make-code lookup; ext selects the E0-prefixed arrow keys.
  always_comb begin
    map_hit = 1'b1;
    map_act = 3'd0;
    if (ext_q) begin
      case (shreg_q)
        8'h75:   map_act = 3'd0;
        8'h72:   map_act = 3'd1;
        8'h6B:   map_act = 3'd2;
        8'h74:   map_act = 3'd3;
        default: map_hit = 1'b0;
      endcase
    end else begin
      case (shreg_q)
        8'h1D:   map_act = 3'd0;
        8'h1B:   map_act = 3'd1;
        8'h1C:   map_act = 3'd2;
        8'h23:   map_act = 3'd3;
        8'h29:   map_act = 3'd4;
        8'h1A:   map_act = 3'd5;
        8'h5A:   map_act = 3'd6;
        default: map_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fall_d     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_d     = stop_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    frame_err  = 1'b0;
    act_valid  = 1'b0;

    // Saturating counter: it holds at the limit in IDLE, so it never wraps.
    if (fall_q) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall_q) begin
          if (!din) begin
            state_d   = SHIFT;
            bit_cnt_d = 4'd0;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            shreg_d = {din, shreg_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            par_d = din;
          end else begin
            stop_d  = din;
            state_d = CHECK;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          frame_err = 1'b1;
          state_d   = IDLE;
          ext_d     = 1'b0;
          brk_d     = 1'b0;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!frame_ok) begin
          frame_err = 1'b1;
          ext_d     = 1'b0;
          brk_d     = 1'b0;
        end else if (shreg_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shreg_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (brk_q) begin
          // Release of a key: consumes both prefixes, no action.
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          act_valid = map_hit;
          ext_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake: a clear in the same cycle as a new action wins and the
    // action is dropped, since there is no queue.
    ready_d   = ready_q;
    data_d    = data_q;
    dropped_d = 1'b0;
    if (ready_q && read_fin) begin
      ready_d   = 1'b0;
      dropped_d = act_valid;
    end else if (act_valid) begin
      if (ready_q) begin
        dropped_d = 1'b1;
      end else begin
        ready_d = 1'b1;
        data_d  = map_act;
      end
    end
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      // Lines idle high, so the chains start at 1 to avoid a false edge.
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= 3'd0;
      dropped_q  <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      dropped_q  <= dropped_d;
    end
  end

  assign ready   = ready_q;
  assign data    = data_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb/tb_ps2_key_mapper.sv - directed self-checking bench for ps2_key_mapper
module tb_ps2_key_mapper;

  localparam int TMO = 2000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_fin = 1'b0;
  logic       ready;
  logic [2:0] data;
  logic       frame_err;
  logic       dropped;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int drop_cnt = 0;
  int rise_cnt = 0;
  logic ready_prev = 1'b0;

  ps2_key_mapper #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk_100M (clk),
    .reset_n  (reset_n),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .read_fin (read_fin),
    .ready    (ready),
    .data     (data),
    .frame_err(frame_err),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
    if (ready === 1'b1 && !ready_prev) rise_cnt <= rise_cnt + 1;
    ready_prev <= (ready === 1'b1);
  end

  // Full frame. Samples outputs 4 and 5 cycles after the stop-bit falling edge
  // is driven: CHECK is visible at the 4th sample, ready/dropped at the 5th.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic fin_at_check,
                            output logic rdy4, output logic fe4, output logic rdy5,
                            output logic drp5, output logic fe5, output logic [2:0] dat5);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clock = 1'b0;
      if (i == 10) begin
        repeat (4) @(negedge clk);
        rdy4 = ready; fe4 = frame_err;
        if (fin_at_check) read_fin = 1'b1;
        @(negedge clk);
        rdy5 = ready; drp5 = dropped; fe5 = frame_err; dat5 = data;
        read_fin = 1'b0;
        repeat (H - 5) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clock = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clock = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic clear_ready();
    @(negedge clk); read_fin = 1'b1;
    @(negedge clk); read_fin = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (data !== 3'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (dropped !== 1'b0) begin n_bad++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_make();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    send_frame(8'h1D, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r4 !== 1'b0) begin n_bad++; $display("FAIL single_early_ready: got %b want 0", r4); end
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd0) begin n_bad++; $display("FAIL single_data: got %0d want 0", v5); end
    n_cmp++; if (d5 !== 1'b0) begin n_bad++; $display("FAIL single_dropped: got %b want 0", d5); end
    @(negedge clk); read_fin = 1'b1;
    @(negedge clk); read_fin = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL single_clear: got %b want 0", ready); end
    n_cmp++; if (data !== 3'd0) begin n_bad++; $display("FAIL single_data_hold: got %0d want 0", data); end
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL fin_idle: got %b want 0", ready); end
  endtask

  task automatic test_extended();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    int r0, dr0;
    r0 = rise_cnt;
    send_frame(8'hE0, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r5 !== 1'b0) begin n_bad++; $display("FAIL ext_prefix_ready: got %b want 0", r5); end
    send_frame(8'h74, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL ext_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd3) begin n_bad++; $display("FAIL ext_data: got %0d want 3", v5); end
    clear_ready();
    dr0 = drop_cnt;
    send_frame(8'hE0, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    send_frame(8'hF0, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    send_frame(8'h74, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    // A bare 74 has no mapping, so it also proves the release cleared ext.
    send_frame(8'h74, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (rise_cnt - r0 !== 1) begin n_bad++; $display("FAIL ext_actions: got %0d want 1", rise_cnt - r0); end
    n_cmp++; if (drop_cnt - dr0 !== 0) begin n_bad++; $display("FAIL release_dropped: got %0d want 0", drop_cnt - dr0); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL release_ready: got %b want 0", ready); end
  endtask

  task automatic test_parity();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (f4 !== 1'b1) begin n_bad++; $display("FAIL parity_err_at_check: got %b want 1", f4); end
    n_cmp++; if (f5 !== 1'b0) begin n_bad++; $display("FAIL parity_err_width: got %b want 0", f5); end
    n_cmp++; if (r5 !== 1'b0) begin n_bad++; $display("FAIL parity_ready: got %b want 0", r5); end
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL parity_err_count: got %0d want 1", fe_cnt - fe0); end
    send_frame(8'h1C, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL parity_good_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd2) begin n_bad++; $display("FAIL parity_good_data: got %0d want 2", v5); end
    clear_ready();
  endtask

  task automatic test_timeout();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    int fe0;
    fe0 = fe_cnt;
    send_partial(8'h29, 5);
    repeat (TMO + 200) @(negedge clk);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL timeout_ready: got %b want 0", ready); end
    send_frame(8'h29, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL timeout_next_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd4) begin n_bad++; $display("FAIL timeout_next_data: got %0d want 4", v5); end
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL timeout_spurious: got %0d want 1", fe_cnt - fe0); end
    clear_ready();
  endtask

  task automatic test_overrun();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    int dr0;
    send_frame(8'h1D, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    dr0 = drop_cnt;
    send_frame(8'h1B, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (d5 !== 1'b1) begin n_bad++; $display("FAIL overrun_dropped: got %b want 1", d5); end
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL overrun_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd0) begin n_bad++; $display("FAIL overrun_data: got %0d want 0", v5); end
    send_frame(8'h1B, 1'b0, 1'b1, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL collide_pre_ready: got %b want 1", r4); end
    n_cmp++; if (r5 !== 1'b0) begin n_bad++; $display("FAIL collide_ready: got %b want 0", r5); end
    n_cmp++; if (d5 !== 1'b1) begin n_bad++; $display("FAIL collide_dropped: got %b want 1", d5); end
    n_cmp++; if (v5 !== 3'd0) begin n_bad++; $display("FAIL collide_data: got %0d want 0", v5); end
    n_cmp++; if (drop_cnt - dr0 !== 2) begin n_bad++; $display("FAIL overrun_drop_count: got %0d want 2", drop_cnt - dr0); end
  endtask

  task automatic test_mapping();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    logic [7:0] code [7];
    logic       ext  [7];
    logic       hit  [7];
    logic [2:0] act  [7];
    code = '{8'h23, 8'h1A, 8'h75, 8'h72, 8'h6B, 8'h15, 8'h1D};
    ext  = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    hit  = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    act  = '{3'd3,  3'd5,  3'd0,  3'd1,  3'd2,  3'd0,  3'd0};
    for (int i = 0; i < 7; i++) begin
      if (ext[i]) send_frame(8'hE0, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
      send_frame(code[i], 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
      n_cmp++;
      if (r5 !== hit[i]) begin n_bad++; $display("FAIL map_ready_%02h: got %b want %b", code[i], r5, hit[i]); end
      if (hit[i]) begin
        n_cmp++;
        if (v5 !== act[i]) begin n_bad++; $display("FAIL map_data_%02h: got %0d want %0d", code[i], v5, act[i]); end
      end
      clear_ready();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic r4, f4, r5, d5, f5; logic [2:0] v5;
    int fe0;
    send_frame(8'h1A, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    send_partial(8'h5A, 6);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", ready); end
    n_cmp++; if (data !== 3'd0) begin n_bad++; $display("FAIL midrst_data: got %0d want 0", data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (dropped !== 1'b0) begin n_bad++; $display("FAIL midrst_dropped: got %b want 0", dropped); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, r4, f4, r5, d5, f5, v5);
    n_cmp++; if (r5 !== 1'b1) begin n_bad++; $display("FAIL midrst_next_ready: got %b want 1", r5); end
    n_cmp++; if (v5 !== 3'd6) begin n_bad++; $display("FAIL midrst_next_data: got %0d want 6", v5); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL midrst_err_count: got %0d want 0", fe_cnt - fe0); end
    clear_ready();
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_extended();
    test_parity();
    test_timeout();
    test_overrun();
    clear_ready();
    test_mapping();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
